// File: rtl/fifo_byte_serializer_pkg.sv
// Shared types for the FIFO-to-byte-stream serializer.
// State encoding and byte-count helpers.
package fifo_byte_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } ser_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_BYTE_W = 8;

  function automatic int nbytes(int dw, int bw);
    return dw / bw;
  endfunction

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NBYTES = nbytes(DEF_DATA_W, DEF_BYTE_W);
  localparam int IDX_W  = idx_w(NBYTES);

endpackage

// File: rtl/fifo_byte_serializer_if.sv
// FIFO read port plus byte stream handshake of the serializer.
// master = serializer side, slave = FIFO/sink side.
interface fifo_byte_serializer_if #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
);
  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_rdata;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;

  modport master (
    input  fifo_empty, fifo_rdata, tx_ready,
    output fifo_rd, tx_data, tx_valid, busy
  );

  modport slave (
    output fifo_empty, fifo_rdata, tx_ready,
    input  fifo_rd, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/fifo_byte_serializer_byte_mux.sv
// Combinational byte selector for the serializer.
// Picks byte[idx] of a word, LSB- or MSB-first.
module fifo_ser_byte_mux #(
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int LSB_FIRST = 1,
  parameter int IDX_W     = 2
) (
  input  logic [DATA_W-1:0] word,
  input  logic [IDX_W-1:0]  idx,
  output logic [BYTE_W-1:0] sel
);
  localparam int NB = DATA_W / BYTE_W;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx == IDX_W'(i)) begin
        sel = word[(LSB_FIRST != 0 ? i : NB-1-i)*BYTE_W +: BYTE_W];
      end
    end
  end
endmodule

// File: rtl/fifo_byte_serializer.sv
// Pops 32-bit FIFO words and streams them out as bytes.
// FIFO_SER_PREFETCH_EN adds a one-word hold stage for gapless output.
module fifo_byte_serializer
  import fifo_byte_serializer_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int LSB_FIRST = 1
) (
  input logic clk,
  input logic rst,
  fifo_byte_serializer_if.master bus
);
  localparam int NB = nbytes(DATA_W, BYTE_W);
  localparam int IW = idx_w(NB);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  ser_state_t        state;
  logic [DATA_W-1:0] shift;
  logic [IW-1:0]     idx;
  logic              hs;
  logic              last;
  logic              pf_ok;

  assign hs   = bus.tx_valid & bus.tx_ready;
  assign last = (idx == LAST);

`ifdef FIFO_SER_PREFETCH_EN
  logic [DATA_W-1:0] hold_data;
  logic              hold_vld;
  logic              pending;

  assign pf_ok = (state == SEND) & !hold_vld & !pending;
  assign bus.busy = (state != IDLE) | hold_vld | pending;
`else
  assign pf_ok = 1'b0;
  assign bus.busy = (state != IDLE);
`endif

  assign bus.fifo_rd = !rst & !bus.fifo_empty
                     & ((state == IDLE) | pf_ok);
  assign bus.tx_valid = (state == SEND);

  fifo_ser_byte_mux #(
    .DATA_W    (DATA_W),
    .BYTE_W    (BYTE_W),
    .LSB_FIRST (LSB_FIRST),
    .IDX_W     (IW)
  ) u_mux (
    .word (shift),
    .idx  (idx),
    .sel  (bus.tx_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      shift <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.fifo_rd) state <= LOAD;
        LOAD: begin
          shift <= bus.fifo_rdata;
          idx   <= '0;
          state <= SEND;
        end
        SEND: if (hs) begin
          if (!last) begin
            idx <= idx + 1'b1;
          end else begin
`ifdef FIFO_SER_PREFETCH_EN
            if (hold_vld) begin
              shift <= hold_data;
              idx   <= '0;
            end else if (pending) begin
              shift <= bus.fifo_rdata;
              idx   <= '0;
            end else begin
              // a pop issued on the final byte is caught by LOAD
              state <= bus.fifo_rd ? LOAD : IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_SER_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data <= '0;
      hold_vld  <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (bus.fifo_rd && state == SEND && !(hs && last)) begin
        pending <= 1'b1;
      end else if (pending) begin
        pending <= 1'b0;
        if (!(hs && last)) begin
          hold_data <= bus.fifo_rdata;
          hold_vld  <= 1'b1;
        end
      end
      if (hold_vld && hs && last) hold_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Scoreboard bench: LSB- and MSB-first serializers on one FIFO model.
// Directed words, back-pressure, streaming and mid-word reset.
module tb_fifo_byte_serializer;
  import fifo_byte_serializer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        empty = 1'b1;
  logic [31:0] rdata = '0;
  logic        ready = 1'b1;

  int n_chk = 0;
  int n_pass = 0;
  int pops = 0;
  int hs_cnt = 0;

  logic [31:0] fq[$];
  logic [7:0]  e0[$];
  logic [7:0]  e1[$];

  always #5 clk = ~clk;

  fifo_byte_serializer_if #(.DATA_W(32), .BYTE_W(8)) b0 ();
  fifo_byte_serializer_if #(.DATA_W(32), .BYTE_W(8)) b1 ();

  assign b0.fifo_empty = empty;
  assign b1.fifo_empty = empty;
  assign b0.fifo_rdata = rdata;
  assign b1.fifo_rdata = rdata;
  assign b0.tx_ready   = ready;
  assign b1.tx_ready   = ready;

  fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .LSB_FIRST(1)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (b0.master)
  );

  fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .LSB_FIRST(0)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (b1.master)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] w, input int nb);
    fq.push_back(w);
    empty = 1'b0;
    for (int i = 0; i < nb; i++) begin
      e0.push_back(w[8*i +: 8]);
      e1.push_back(w[8*(3-i) +: 8]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_hs(input int n);
    int tgt;
    logic ok;
    tgt = hs_cnt + n;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step(1);
      if (hs_cnt >= tgt) ok = 1'b1;
    end
    check("wait_handshakes", ok, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!b0.busy && !b1.busy && e0.size() == 0 && e1.size() == 0
          && fq.size() == 0) ok = 1'b1;
    end
    check(name, ok, 1'b1);
  endtask

  // FIFO model: registered read data, updated just after the pop edge
  initial begin
    logic rdv;
    forever begin
      @(negedge clk);
      rdv = b0.fifo_rd;
      if (rdv || b1.fifo_rd) begin
        check("rd_while_empty", empty, 1'b0);
        check("rd_lsb_vs_msb", b1.fifo_rd, rdv);
      end
      @(posedge clk);
      #1;
      if (rdv && fq.size() > 0) begin
        rdata = fq.pop_front();
        pops++;
      end
      empty = (fq.size() == 0);
    end
  end

  initial begin
    logic       stalled;
    logic [7:0] held0;
    logic [7:0] held1;
    stalled = 1'b0;
    held0 = '0;
    held1 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", b0.tx_valid, 1'b1);
          check("stall_data_lsb", b0.tx_data, held0);
          check("stall_data_msb", b1.tx_data, held1);
        end
        if (b0.tx_valid && ready) begin
          hs_cnt++;
          if (e0.size() == 0) begin
            n_chk++;
            $display("FAIL extra_byte_lsb: got %h expected none", b0.tx_data);
          end else check("byte_lsb", b0.tx_data, e0.pop_front());
        end
        if (b1.tx_valid && ready) begin
          if (e1.size() == 0) begin
            n_chk++;
            $display("FAIL extra_byte_msb: got %h expected none", b1.tx_data);
          end else check("byte_msb", b1.tx_data, e1.pop_front());
        end
        stalled = b0.tx_valid && !ready;
        held0 = b0.tx_data;
        held1 = b1.tx_data;
      end
    end
  end

  initial begin
    int p;
    rst = 1'b1;
    ready = 1'b1;
    #1;
    push(32'hA1B2C3D4, 4);
    repeat (3) begin
      @(negedge clk);
      check("rst_fifo_rd", b0.fifo_rd, 1'b0);
      check("rst_tx_valid", b0.tx_valid, 1'b0);
      check("rst_tx_data", b0.tx_data, 8'h00);
      check("rst_busy", b0.busy, 1'b0);
      check("rst_tx_valid_msb", b1.tx_valid, 1'b0);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("first_pop", b0.fifo_rd, 1'b1);
    @(negedge clk);
    check("load_no_valid", b0.tx_valid, 1'b0);
    @(negedge clk);
    check("first_byte_lat", b0.tx_valid, 1'b1);
    repeat (3) @(negedge clk);
    check("busy_last_byte", b0.busy, 1'b1);
    @(negedge clk);
    check("busy_after_word", b0.busy, 1'b0);
    check("one_pop", pops, 1);

    step(1);
    push(32'h11223344, 4);
    wait_hs(2);
    p = pops;
    ready = 1'b0;
    step(5);
    check("no_pop_in_stall", pops, p);
    ready = 1'b1;
    wait_idle("idle_after_stall");
    check("pops_after_stall", pops, 2);

    step(1);
    push(32'h03020100, 4);
    push(32'h07060504, 4);
    push(32'h0B0A0908, 4);
`ifdef FIFO_SER_PREFETCH_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        seen = b0.tx_valid;
      end
      check("stream_start", seen, 1'b1);
      for (int i = 0; i < 11; i++) begin
        @(negedge clk);
        check("stream_no_bubble", b0.tx_valid, 1'b1);
      end
    end
`endif
    wait_idle("idle_after_stream");
    check("pops_after_stream", pops, 5);

    step(1);
    push(32'hCAFEF00D, 2);
    wait_hs(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", b0.tx_valid, 1'b0);
    check("midrst_busy", b0.busy, 1'b0);
    check("midrst_data", b0.tx_data, 8'h00);
    #1;
    rst = 1'b0;
    step(3);
    check("midrst_no_resend", b0.tx_valid, 1'b0);
    push(32'h89ABCDEF, 4);
    wait_idle("idle_after_midrst");
    check("total_pops", pops, 7);
    check("sb_empty_lsb", e0.size(), 0);
    check("sb_empty_msb", e1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
